// File: rtl/elevator_ctrl_n_pkg.sv
// ---------------------------------------------------------------------------
// elevator_ctrl_n_pkg
// Shared definitions for the N-floor elevator controller: FSM state
// encodings, direction constants and the direction-selection helper used
// when leaving IDLE.
// ---------------------------------------------------------------------------
package elevator_ctrl_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Collector (SCAN) rule: keep travelling the current way while calls
  // remain in that direction, otherwise turn around.
  function automatic logic next_dir(input logic dir,
                                    input logic call_above,
                                    input logic call_below);
    logic res;
    if (dir == DIR_UP) begin
      res = call_above ? DIR_UP : DIR_DOWN;
    end else begin
      res = call_below ? DIR_DOWN : DIR_UP;
    end
    return res;
  endfunction

endpackage

// File: rtl/elevator_ctrl_n_door_timer.sv
// ---------------------------------------------------------------------------
// door_timer
// Loadable down-counter that times the door dwell.
// Ports:
//   Clk   - system clock, rising edge
//   Reset - asynchronous, active-low
//   load  - reload the counter with DOOR_CYCLES-1 (priority over en)
//   en    - decrement by one, saturating at zero
//   zero  - counter currently reads zero
// ---------------------------------------------------------------------------
module door_timer #(
  parameter int DOOR_CYCLES = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic load,
  input  logic en,
  output logic zero
);

  // A one-cycle dwell still needs a 1-bit counter.
  localparam int CW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DOOR_CYCLES - 1);

  logic [CW-1:0] cnt_r;

  // Down-counter: load wins over decrement, holds at zero.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= RELOAD;
    end else if (en && (cnt_r != '0)) begin
      cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == '0);

endmodule

// File: rtl/elevator_ctrl_n.sv
// ---------------------------------------------------------------------------
// elevator_ctrl_n
// N-floor elevator controller. Latches cabin/hall calls, serves them in
// collector (SCAN) order, drives motor enable/direction from one-hot floor
// sensors, times the door and holds it open under overload.
// Ports:
//   Clk, Reset      - clock (rising edge), async active-low reset
//   I, E            - cabin / hall call buttons, bit f = floor f
//   S               - floor sensors, one-hot when level with a floor
//   R               - overload sensor
//   M, D            - motor enable, direction (1 = up)
//   P, W            - door open, overload warning
//   Floor           - last floor reached
//   Pending         - latched unserved calls
// All outputs are registered.
// ---------------------------------------------------------------------------
module elevator_ctrl_n
  import elevator_ctrl_n_pkg::*;
#(
  parameter int FLOORS      = 4,
  parameter int FLOOR_W     = $clog2(FLOORS),
  parameter int DOOR_CYCLES = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [FLOORS-1:0]  I,
  input  logic [FLOORS-1:0]  E,
  input  logic [FLOORS-1:0]  S,
  input  logic               R,
  output logic               M,
  output logic               D,
  output logic               P,
  output logic               W,
  output logic [FLOOR_W-1:0] Floor,
  output logic [FLOORS-1:0]  Pending
);

  state_t               state_r;
  state_t               nxt_state_s;
  logic [FLOORS-1:0]    pending_r;
  logic [FLOORS-1:0]    pending_nxt_s;
  logic [FLOOR_W-1:0]   floor_r;
  logic                 m_r, d_r, p_r, w_r;
  logic                 dir_nxt_s;

  logic [FLOORS-1:0]    calls_s;
  logic [FLOORS-1:0]    latch_s;
  logic [FLOORS-1:0]    clear_s;
  logic [FLOORS-1:0]    floor_bit_s;
  logic [FLOORS-1:0]    above_s;
  logic [FLOORS-1:0]    below_s;
  logic                 call_above_s;
  logic                 call_below_s;

  logic                 sens_hit_s;
  logic                 sens_multi_s;
  logic                 sens_valid_s;
  logic [FLOOR_W-1:0]   sens_idx_s;
  logic [FLOORS-1:0]    sens_bit_s;
  logic                 shaft_end_s;

  logic                 door_call_s;
  logic                 tmr_load_s;
  logic                 tmr_en_s;
  logic                 tmr_zero_s;

  door_timer #(
    .DOOR_CYCLES (DOOR_CYCLES)
  ) u_door_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (tmr_load_s),
    .en    (tmr_en_s),
    .zero  (tmr_zero_s)
  );

  // Floor masks, sensor decode and call classification.
  always_comb begin
    floor_bit_s          = '0;
    floor_bit_s[floor_r] = 1'b1;
    above_s              = '0;
    below_s              = '0;
    for (int f = 0; f < FLOORS; f++) begin
      above_s[f] = (FLOOR_W'(f) > floor_r);
      below_s[f] = (FLOOR_W'(f) < floor_r);
    end
    call_above_s = |(pending_r & above_s);
    call_below_s = |(pending_r & below_s);

    // A sensor reading counts only when exactly one bit is set.
    sens_hit_s   = 1'b0;
    sens_multi_s = 1'b0;
    sens_idx_s   = '0;
    for (int f = 0; f < FLOORS; f++) begin
      if (S[f]) begin
        if (sens_hit_s) begin
          sens_multi_s = 1'b1;
        end else begin
          sens_hit_s = 1'b1;
          sens_idx_s = FLOOR_W'(f);
        end
      end else begin
        sens_hit_s = sens_hit_s;
      end
    end
    sens_valid_s           = sens_hit_s && !sens_multi_s;
    sens_bit_s             = '0;
    sens_bit_s[sens_idx_s] = 1'b1;
    shaft_end_s = ((sens_idx_s == '0) && (d_r == DIR_DOWN)) ||
                  ((sens_idx_s == FLOOR_W'(FLOORS - 1)) && (d_r == DIR_UP));

    // A call for the current floor while the door is open only reopens it.
    calls_s     = I | E;
    door_call_s = (state_r == ST_DOOR) && (|(calls_s & floor_bit_s));
    if (state_r == ST_DOOR) begin
      latch_s = calls_s & ~floor_bit_s;
    end else begin
      latch_s = calls_s;
    end
  end

  // Next-state, call clearing and door-timer control.
  always_comb begin
    nxt_state_s = state_r;
    clear_s     = '0;
    tmr_load_s  = 1'b0;
    tmr_en_s    = 1'b0;
    dir_nxt_s   = d_r;
    case (state_r)
      ST_IDLE: begin
        if (|(pending_r & floor_bit_s)) begin
          nxt_state_s = ST_DOOR;
          clear_s     = floor_bit_s;
          tmr_load_s  = 1'b1;
        end else if (call_above_s || call_below_s) begin
          nxt_state_s = ST_MOVE;
          dir_nxt_s   = next_dir(d_r, call_above_s, call_below_s);
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_MOVE: begin
        if (sens_valid_s) begin
          if (|(pending_r & sens_bit_s)) begin
            nxt_state_s = ST_DOOR;
            clear_s     = sens_bit_s;
            tmr_load_s  = 1'b1;
          end else if (shaft_end_s) begin
            nxt_state_s = ST_IDLE;
          end else begin
            nxt_state_s = ST_MOVE;
          end
        end else begin
          nxt_state_s = ST_MOVE;
        end
      end
      ST_DOOR: begin
        if (door_call_s) begin
          nxt_state_s = ST_DOOR;
          tmr_load_s  = 1'b1;
        end else if (tmr_zero_s) begin
          nxt_state_s = R ? ST_HOLD : ST_IDLE;
        end else begin
          nxt_state_s = ST_DOOR;
          tmr_en_s    = 1'b1;
        end
      end
      ST_HOLD: begin
        if (R) begin
          nxt_state_s = ST_HOLD;
        end else begin
          nxt_state_s = ST_DOOR;
          tmr_load_s  = 1'b1;
        end
      end
      default: begin
        nxt_state_s = ST_IDLE;
      end
    endcase
    pending_nxt_s = (pending_r | latch_s) & ~clear_s;
  end

  // State and registered outputs; outputs are decoded from the next state
  // so they change on the same edge as the state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r   <= ST_IDLE;
      pending_r <= '0;
      floor_r   <= '0;
      m_r       <= 1'b0;
      d_r       <= DIR_UP;
      p_r       <= 1'b0;
      w_r       <= 1'b0;
    end else begin
      state_r   <= nxt_state_s;
      pending_r <= pending_nxt_s;
      d_r       <= dir_nxt_s;
      m_r       <= (nxt_state_s == ST_MOVE);
      p_r       <= (nxt_state_s == ST_DOOR) || (nxt_state_s == ST_HOLD);
      w_r       <= (nxt_state_s == ST_HOLD);
      if ((state_r == ST_MOVE) && sens_valid_s) begin
        floor_r <= sens_idx_s;
      end else begin
        floor_r <= floor_r;
      end
    end
  end

  assign M       = m_r;
  assign D       = d_r;
  assign P       = p_r;
  assign W       = w_r;
  assign Floor   = floor_r;
  assign Pending = pending_r;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// ---------------------------------------------------------------------------
// tb_elevator_ctrl_n
// Directed bench for elevator_ctrl_n with FLOORS=4, DOOR_CYCLES=3.
// Inputs change #1 after the rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_elevator_ctrl_n;

  logic       Clk;
  logic       Reset;
  logic [3:0] I, E, S;
  logic       R;
  logic       M, D, P, W;
  logic [1:0] Floor;
  logic [3:0] Pending;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  elevator_ctrl_n #(
    .FLOORS      (4),
    .DOOR_CYCLES (3)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .I       (I),
    .E       (E),
    .S       (S),
    .R       (R),
    .M       (M),
    .D       (D),
    .P       (P),
    .W       (W),
    .Floor   (Floor),
    .Pending (Pending)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b0; I = 4'b0000; E = 4'b0000; S = 4'b0000; R = 1'b0;

    // Reset held for two cycles
    tick(); tick();
    chk("rst_M", 32'(M), 32'd0);
    chk("rst_D", 32'(D), 32'd1);
    chk("rst_P", 32'(P), 32'd0);
    chk("rst_W", 32'(W), 32'd0);
    chk("rst_Floor", 32'(Floor), 32'd0);
    chk("rst_Pending", 32'(Pending), 32'd0);
    Reset = 1'b1;
    tick(); tick(); tick();
    chk("idle_M", 32'(M), 32'd0);
    chk("idle_P", 32'(P), 32'd0);

    // Single trip 0 -> 2
    E = 4'b0100; tick();
    chk("trip_latch", 32'(Pending), 32'h4);
    chk("trip_latch_M", 32'(M), 32'd0);
    E = 4'b0000; tick();
    chk("trip_start_M", 32'(M), 32'd1);
    chk("trip_start_D", 32'(D), 32'd1);
    S = 4'b0010; tick();
    chk("trip_f1_Floor", 32'(Floor), 32'd1);
    chk("trip_f1_M", 32'(M), 32'd1);
    S = 4'b0100; tick();
    chk("trip_f2_M", 32'(M), 32'd0);
    chk("trip_f2_P", 32'(P), 32'd1);
    chk("trip_f2_Floor", 32'(Floor), 32'd2);
    chk("trip_f2_Pending", 32'(Pending), 32'd0);
    S = 4'b0000; tick();
    chk("trip_door1", 32'(P), 32'd1);
    tick();
    chk("trip_door2", 32'(P), 32'd1);
    tick();
    chk("trip_door_end", 32'(P), 32'd0);

    // Door reopen at floor 2
    I = 4'b0100; tick();
    I = 4'b0000; tick();
    chk("reopen_open", 32'(P), 32'd1);
    tick();
    I = 4'b0100; tick();
    I = 4'b0000;
    chk("reopen_Pending", 32'(Pending), 32'd0);
    chk("reopen_P0", 32'(P), 32'd1);
    tick();
    chk("reopen_P1", 32'(P), 32'd1);
    tick();
    chk("reopen_P2", 32'(P), 32'd1);
    tick();
    chk("reopen_end", 32'(P), 32'd0);

    // Overload through door expiry
    I = 4'b0100; tick();
    I = 4'b0000; tick();
    R = 1'b1; tick(); tick(); tick();
    chk("ovl_W", 32'(W), 32'd1);
    chk("ovl_P", 32'(P), 32'd1);
    tick();
    chk("ovl_hold_W", 32'(W), 32'd1);
    chk("ovl_hold_P", 32'(P), 32'd1);
    R = 1'b0; tick();
    chk("ovl_rel_W", 32'(W), 32'd0);
    chk("ovl_rel_P0", 32'(P), 32'd1);
    tick();
    chk("ovl_rel_P1", 32'(P), 32'd1);
    tick();
    chk("ovl_rel_P2", 32'(P), 32'd1);
    tick();
    chk("ovl_end_P", 32'(P), 32'd0);
    chk("ovl_end_M", 32'(M), 32'd0);

    // SCAN order: re-home to floor 0, head up, latch calls at 0 and 3
    Reset = 1'b0; tick();
    Reset = 1'b1;
    chk("scan_home", 32'(Floor), 32'd0);
    I = 4'b1000; tick();
    I = 4'b0000; tick();
    chk("scan_up_M", 32'(M), 32'd1);
    S = 4'b0010; I = 4'b0001; tick();
    I = 4'b0000;
    chk("scan_f1_Floor", 32'(Floor), 32'd1);
    chk("scan_f1_Pending", 32'(Pending), 32'h9);
    S = 4'b0000; tick();
    chk("scan_gap_M", 32'(M), 32'd1);
    S = 4'b1000; tick();
    chk("scan_f3_Floor", 32'(Floor), 32'd3);
    chk("scan_f3_P", 32'(P), 32'd1);
    chk("scan_f3_Pending", 32'(Pending), 32'h1);
    S = 4'b0000; tick(); tick(); tick();
    chk("scan_idle_M", 32'(M), 32'd0);
    chk("scan_idle_P", 32'(P), 32'd0);
    chk("scan_idle_D", 32'(D), 32'd1);
    tick();
    chk("scan_rev_D", 32'(D), 32'd0);
    chk("scan_rev_M", 32'(M), 32'd1);
    S = 4'b0100; tick();
    S = 4'b0010; tick();
    chk("scan_down_M", 32'(M), 32'd1);
    S = 4'b0001; tick();
    S = 4'b0000;
    chk("scan_f0_Floor", 32'(Floor), 32'd0);
    chk("scan_f0_P", 32'(P), 32'd1);
    chk("scan_f0_Pending", 32'(Pending), 32'd0);
    tick(); tick(); tick();

    // Glitchy sensor, then async reset mid-move
    E = 4'b0100; tick();
    E = 4'b0000; tick();
    chk("glitch_start_M", 32'(M), 32'd1);
    S = 4'b0110; tick();
    chk("glitch_Floor", 32'(Floor), 32'd0);
    chk("glitch_M", 32'(M), 32'd1);
    S = 4'b0000;
    #2 Reset = 1'b0;
    #1;
    chk("async_M", 32'(M), 32'd0);
    chk("async_Pending", 32'(Pending), 32'd0);
    tick();
    Reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
